mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- Shares the single memory-side read-request channel between NR_PORTS cache requesters (port 0 = icache refill, port 1 = dcache miss in the default two-port build).
- Round-robin arbitration with a registered output stage; requester index is prefixed onto the downstream transaction ID.
- Tracks outstanding transactions per port, capped at MAX_OUTSTANDING, and routes responses back to their requester by ID.
- Sits between the cache subsystem and the AXI adapter.

Parameters:
- NR_PORTS, 2, number of requesters; must be ≥2 and a power of two.
- TID_WIDTH, 4, downstream transaction ID width (matches the memory TID width).
- ADDR_WIDTH, 64, request address width.
- DATA_WIDTH, 64, response data width.
- MAX_OUTSTANDING, 7, maximum in-flight requests per port; must be ≥1.
- IDX_W, $clog2(NR_PORTS), derived; local ID width LTID_W = TID_WIDTH-IDX_W, must be ≥1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NR_PORTS  per-port request valid
- req_ready_o  out  NR_PORTS  per-port request accepted (one-hot or zero)
- req_addr_i  in  NR_PORTS*ADDR_WIDTH  per-port address
- req_tid_i  in  NR_PORTS*LTID_W  per-port local ID
- mem_req_valid_o  out  1  downstream request valid
- mem_req_ready_i  in  1  downstream request ready
- mem_req_addr_o  out  ADDR_WIDTH  downstream address
- mem_req_tid_o  out  TID_WIDTH  {port index, local ID}
- mem_rsp_valid_i  in  1  response beat valid (always accepted)
- mem_rsp_last_i  in  1  final beat of transaction
- mem_rsp_tid_i  in  TID_WIDTH  response ID
- mem_rsp_data_i  in  DATA_WIDTH  response data
- rsp_valid_o  out  NR_PORTS  per-port response valid
- rsp_last_o  out  1  last beat
- rsp_tid_o  out  LTID_W  local ID
- rsp_data_o  out  DATA_WIDTH  response data
- err_o  out  1  sticky: response to a port with zero outstanding

Behaviour:
- Reset: all outputs 0; FSM IDLE; RR pointer 0; outstanding counters 0; err_o 0. Reset mid-transaction drops all tracking; downstream must be reset together with this block.
- Eligible port: req_valid_i[p] && outstanding[p] < MAX_OUTSTANDING.
- RR: first eligible port starting at pointer, scanning upward with wrap. On grant g, pointer <= (g+1) mod NR_PORTS.
- FSM IDLE:
  - If any port is eligible: assert req_ready_o[g] combinationally in the same cycle.
  - Capture addr and {g, req_tid_i[g]} into the output register; outstanding[g]++; go to VALID.
  - If no port is eligible: stay IDLE.
- FSM VALID:
  - mem_req_valid_o=1; addr and tid are held stable until mem_req_ready_i.
  - On handshake with a port eligible: back-to-back capture, same as IDLE (no bubble); stay VALID.
  - On handshake with no port eligible: go IDLE.
  - Without handshake: req_ready_o=0.
- Grant-to-mem_req_valid_o latency: 1 cycle. Throughput: 1 request/cycle.
- Response path (combinational, 0 latency):
  - rsp_valid_o[mem_rsp_tid_i[TID_WIDTH-1 -: IDX_W]] = mem_rsp_valid_i.
  - rsp_tid_o = low LTID_W bits of mem_rsp_tid_i; data and last pass through.
- Counters:
  - A beat with last=1 decrements the addressed port's counter.
  - Increment and decrement on the same port in the same cycle: counter unchanged.
  - Counter never exceeds MAX_OUTSTANDING.
  - last=1 to a port whose counter is 0: counter stays 0, err_o set (cleared only by reset), response still forwarded.
- A port at MAX_OUTSTANDING is skipped; the pointer does not advance for it.

Optional Feature:
- Macro MEM_REQ_ARBITER_PERF_EN.
- When defined:
  - Extra output perf_stall_cnt_o (32 bits) counts cycles with mem_req_valid_o && !mem_req_ready_i.
  - Extra output perf_full_o (NR_PORTS bits) flags ports currently at MAX_OUTSTANDING.
  - Counter saturates at 32'hFFFF_FFFF; reset value 0.
- When undefined: both ports and their logic are absent; no behaviour change otherwise.

Test Plan:
- Both ports valid continuously, mem_req_ready_i=1, ports 0 and 1 with local IDs 3 and 5 -> grants alternate 0,1,0,1; mem_req_tid_o alternates 4'h3, 4'hD; no idle cycle between them.
- Port 0 issues 7 requests with no responses -> 8th blocked, req_ready_o[0]=0; port 1 still granted. One last-beat with tid 4'h0 -> port 0 granted the next cycle.
- mem_req_ready_i held 0 for 5 cycles with mem_req_valid_o=1 -> mem_req_addr_o/tid_o stable; req_ready_o=0 for all ports.
- Same-cycle grant of port 1 and last-beat for port 1 with counter=2 -> counter stays 2.
- 4-beat response with tid 4'hA (last on beat 4) -> rsp_valid_o[1] for 4 cycles, rsp_tid_o=3'h2; counter decrements once.
- Last-beat with tid 4'h9 while port 1 counter=0 -> err_o=1 next cycle and remains 1; rst_ni low -> err_o=0 and all counters 0.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Round-robin read-request arbiter with per-port outstanding tracking and ID-routed responses.
// Optional perf counters enabled by defining MEM_REQ_ARBITER_PERF_EN.
module mem_req_arbiter #(
    parameter int NR_PORTS        = 2,
    parameter int TID_WIDTH       = 4,
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 7,
    localparam int IDX_W          = $clog2(NR_PORTS),
    localparam int LTID_W         = TID_WIDTH - IDX_W
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NR_PORTS-1:0]            req_valid_i,
    output logic [NR_PORTS-1:0]            req_ready_o,
    input  logic [NR_PORTS*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NR_PORTS*LTID_W-1:0]     req_tid_i,
    output logic                           mem_req_valid_o,
    input  logic                           mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]          mem_req_addr_o,
    output logic [TID_WIDTH-1:0]           mem_req_tid_o,
    input  logic                           mem_rsp_valid_i,
    input  logic                           mem_rsp_last_i,
    input  logic [TID_WIDTH-1:0]           mem_rsp_tid_i,
    input  logic [DATA_WIDTH-1:0]          mem_rsp_data_i,
    output logic [NR_PORTS-1:0]            rsp_valid_o,
    output logic                           rsp_last_o,
    output logic [LTID_W-1:0]              rsp_tid_o,
    output logic [DATA_WIDTH-1:0]          rsp_data_o,
    output logic                           err_o
`ifdef MEM_REQ_ARBITER_PERF_EN
    ,
    output logic [31:0]                    perf_stall_cnt_o,
    output logic [NR_PORTS-1:0]            perf_full_o
`endif
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {S_IDLE, S_VALID} state_e;

    state_e                state_q;
    logic [IDX_W-1:0]      ptr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [TID_WIDTH-1:0]  tid_q;
    logic [CNT_W-1:0]      cnt_q [NR_PORTS];
    logic [CNT_W-1:0]      cnt_d [NR_PORTS];
    logic                  err_q, err_d;

    logic [NR_PORTS-1:0]   elig, inc_v, dec_v;
    logic [IDX_W-1:0]      scan_idx, gnt_idx, rsp_idx;
    logic                  found, can_issue, gnt, rsp_dec;

    always_comb begin
        for (int p = 0; p < NR_PORTS; p++) begin
            elig[p] = req_valid_i[p] && (cnt_q[p] < CNT_W'(MAX_OUTSTANDING));
        end
    end

    // The output register may be refilled when empty or draining this cycle.
    assign can_issue = (state_q == S_IDLE) || mem_req_ready_i;

    always_comb begin
        found    = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int i = 0; i < NR_PORTS; i++) begin
            scan_idx = ptr_q + IDX_W'(i);
            if (!found && elig[scan_idx]) begin
                found   = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    assign gnt = found && can_issue;

    always_comb begin
        req_ready_o = '0;
        if (gnt) req_ready_o[gnt_idx] = 1'b1;
    end

    assign rsp_idx = mem_rsp_tid_i[TID_WIDTH-1 -: IDX_W];
    assign rsp_dec = mem_rsp_valid_i && mem_rsp_last_i;

    always_comb begin
        rsp_valid_o          = '0;
        rsp_valid_o[rsp_idx] = mem_rsp_valid_i;
    end

    assign rsp_last_o = mem_rsp_last_i;
    assign rsp_tid_o  = mem_rsp_tid_i[LTID_W-1:0];
    assign rsp_data_o = mem_rsp_data_i;

    always_comb begin
        inc_v = '0;
        dec_v = '0;
        if (gnt) inc_v[gnt_idx] = 1'b1;
        if (rsp_dec) dec_v[rsp_idx] = 1'b1;
    end

    // A last beat to an idle port flags an error instead of underflowing.
    always_comb begin
        err_d = err_q;
        for (int p = 0; p < NR_PORTS; p++) begin
            cnt_d[p] = cnt_q[p];
            if (dec_v[p] && cnt_q[p] == '0) err_d = 1'b1;
            if (inc_v[p] && !(dec_v[p] && cnt_q[p] != '0)) begin
                cnt_d[p] = cnt_q[p] + CNT_W'(1);
            end else if (!inc_v[p] && dec_v[p] && cnt_q[p] != '0) begin
                cnt_d[p] = cnt_q[p] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
            for (int p = 0; p < NR_PORTS; p++) cnt_q[p] <= '0;
        end else begin
            err_q <= err_d;
            for (int p = 0; p < NR_PORTS; p++) cnt_q[p] <= cnt_d[p];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            addr_q  <= '0;
            tid_q   <= '0;
        end else if (gnt) begin
            state_q <= S_VALID;
            ptr_q   <= gnt_idx + IDX_W'(1);
            addr_q  <= req_addr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            tid_q   <= {gnt_idx, req_tid_i[gnt_idx*LTID_W +: LTID_W]};
        end else if (can_issue) begin
            state_q <= S_IDLE;
        end
    end

    assign mem_req_valid_o = (state_q == S_VALID);
    assign mem_req_addr_o  = addr_q;
    assign mem_req_tid_o   = tid_q;
    assign err_o           = err_q;

`ifdef MEM_REQ_ARBITER_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else if (mem_req_valid_o && !mem_req_ready_i && stall_q != '1) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    always_comb begin
        for (int p = 0; p < NR_PORTS; p++) begin
            perf_full_o[p] = (cnt_q[p] == CNT_W'(MAX_OUTSTANDING));
        end
    end

    assign perf_stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios then random traffic
// checked against a transaction-level reference model.
module tb_mem_req_arbiter;
    localparam int MAXO = 7;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_ready_o;
    logic [127:0] req_addr_i;
    logic [5:0]  req_tid_i;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [63:0] mem_req_addr_o;
    logic [3:0]  mem_req_tid_o;
    logic        mem_rsp_valid_i;
    logic        mem_rsp_last_i;
    logic [3:0]  mem_rsp_tid_i;
    logic [63:0] mem_rsp_data_i;
    logic [1:0]  rsp_valid_o;
    logic        rsp_last_o;
    logic [2:0]  rsp_tid_o;
    logic [63:0] rsp_data_o;
    logic        err_o;
`ifdef MEM_REQ_ARBITER_PERF_EN
    logic [31:0] perf_stall_cnt_o;
    logic [1:0]  perf_full_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int          m_cnt [2];
    int          m_ptr;
    bit          m_v;
    logic [63:0] m_addr;
    logic [3:0]  m_tid;
    bit          m_err;

    always #5 clk = ~clk;

    mem_req_arbiter dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_addr_i      (req_addr_i),
        .req_tid_i       (req_tid_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_tid_o   (mem_req_tid_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_last_i  (mem_rsp_last_i),
        .mem_rsp_tid_i   (mem_rsp_tid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_last_o      (rsp_last_o),
        .rsp_tid_o       (rsp_tid_o),
        .rsp_data_o      (rsp_data_o),
        .err_o           (err_o)
`ifdef MEM_REQ_ARBITER_PERF_EN
        ,
        .perf_stall_cnt_o(perf_stall_cnt_o),
        .perf_full_o     (perf_full_o)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_ni          = 1'b0;
        req_valid_i     = '0;
        req_addr_i      = '0;
        req_tid_i       = '0;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_last_i  = 1'b0;
        mem_rsp_tid_i   = '0;
        mem_rsp_data_i  = '0;
        #13;
        chk("rst_valid", {63'd0, mem_req_valid_o}, 64'd0);
        chk("rst_ready", {62'd0, req_ready_o}, 64'd0);
        chk("rst_err",   {63'd0, err_o}, 64'd0);
        chk("rst_addr",  mem_req_addr_o, 64'd0);
        chk("rst_tid",   {60'd0, mem_req_tid_o}, 64'd0);
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        m_ptr    = 0;
        m_v      = 0;
        m_addr   = '0;
        m_tid    = '0;
        m_err    = 0;
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    // One cycle: check registered outputs, drive inputs, check the
    // combinational outputs, advance the model, then move to next negedge.
    task automatic step(input logic [1:0] v, input logic rdy, input logic rv,
                        input logic rl, input logic [3:0] rt, input logic [5:0] tids);
        bit          fnd;
        int          g, p, dp;
        bit          can, dec, dp_zero;
        logic [1:0]  exp_rdy, exp_rv;

        chk("req_valid", {63'd0, mem_req_valid_o}, {63'd0, m_v});
        if (m_v) begin
            chk("req_addr", mem_req_addr_o, m_addr);
            chk("req_tid", {60'd0, mem_req_tid_o}, {60'd0, m_tid});
        end
        chk("err", {63'd0, err_o}, {63'd0, m_err});

        req_valid_i     = v;
        mem_req_ready_i = rdy;
        req_addr_i      = {$urandom, $urandom, $urandom, $urandom};
        req_tid_i       = tids;
        mem_rsp_valid_i = rv;
        mem_rsp_last_i  = rl;
        mem_rsp_tid_i   = rt;
        mem_rsp_data_i  = {$urandom, $urandom};
        #1;

        can = !m_v || rdy;
        fnd = 0;
        g   = 0;
        for (int k = 0; k < 2; k++) begin
            p = (m_ptr + k) % 2;
            if (!fnd && can && v[p] && m_cnt[p] < MAXO) begin
                fnd = 1;
                g   = p;
            end
        end
        exp_rdy = fnd ? 2'(1 << g) : 2'b00;
        chk("req_ready", {62'd0, req_ready_o}, {62'd0, exp_rdy});
        exp_rv = rv ? 2'(1 << rt[3]) : 2'b00;
        chk("rsp_valid", {62'd0, rsp_valid_o}, {62'd0, exp_rv});
        if (rv) begin
            chk("rsp_tid", {61'd0, rsp_tid_o}, {61'd0, rt[2:0]});
            chk("rsp_last", {63'd0, rsp_last_o}, {63'd0, rl});
            chk("rsp_data", rsp_data_o, mem_rsp_data_i);
        end

        dp      = rt[3];
        dec     = rv && rl;
        dp_zero = (m_cnt[dp] == 0);
        if (dec && dp_zero) m_err = 1;
        if (fnd) m_cnt[g]++;
        if (dec && !dp_zero) m_cnt[dp]--;
        if (fnd) begin
            m_v    = 1;
            m_addr = req_addr_i[g*64 +: 64];
            m_tid  = {g[0], req_tid_i[g*3 +: 3]};
            m_ptr  = (g + 1) % 2;
        end else if (can) begin
            m_v = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [1:0] rv_v;
    int         rp;
    bit         rrv, rrl;

    initial begin
        do_reset();

        // alternating grants, tids 3 and D
        repeat (4) step(2'b11, 1'b1, 1'b0, 1'b0, 4'h0, {3'd5, 3'd3});
        chk("alt_tid_last", {60'd0, mem_req_tid_o}, 64'hD);
        step(2'b00, 1'b1, 1'b0, 1'b0, 4'h0, 6'd0);

        // grant to port 1 coinciding with its last beat
        step(2'b10, 1'b1, 1'b1, 1'b1, 4'h8, {3'd1, 3'd0});

        // four-beat burst to port 1, local id 2
        repeat (3) step(2'b00, 1'b1, 1'b1, 1'b0, 4'hA, 6'd0);
        step(2'b00, 1'b1, 1'b1, 1'b1, 4'hA, 6'd0);

        // fill port 0 to the cap; port 1 still gets through
        repeat (8) step(2'b01, 1'b1, 1'b0, 1'b0, 4'h0, 6'd4);
        chk("p0_full", {63'd0, req_ready_o[0]}, 64'd0);
        step(2'b11, 1'b1, 1'b0, 1'b0, 4'h0, 6'd4);
        step(2'b01, 1'b1, 1'b1, 1'b1, 4'h0, 6'd4);
        step(2'b01, 1'b1, 1'b0, 1'b0, 4'h0, 6'd4);

        // downstream stall
        repeat (5) step(2'b11, 1'b0, 1'b0, 1'b0, 4'h0, 6'd7);
        step(2'b00, 1'b1, 1'b0, 1'b0, 4'h0, 6'd0);

        // drain port 1 then hit it once more to raise err
        for (int i = 0; i < 16 && m_cnt[1] > 0; i++) step(2'b00, 1'b1, 1'b1, 1'b1, 4'h8, 6'd0);
        step(2'b00, 1'b1, 1'b1, 1'b1, 4'h9, 6'd0);
        repeat (3) step(2'b00, 1'b1, 1'b0, 1'b0, 4'h0, 6'd0);
        chk("err_sticky", {63'd0, err_o}, 64'd1);
        do_reset();

        // random traffic
        repeat (3000) begin
            rv_v = 2'($urandom_range(0, 3));
            rp   = $urandom_range(0, 1);
            rrv  = ($urandom_range(0, 2) == 0);
            if (m_cnt[rp] > 0) rrl = ($urandom_range(0, 1) == 0);
            else rrl = ($urandom_range(0, 199) == 0);
            step(rv_v, ($urandom_range(0, 3) != 0), rrv, rrl,
                 {rp[0], 3'($urandom_range(0, 7))}, 6'($urandom_range(0, 63)));
        end

        do_reset();
        step(2'b00, 1'b1, 1'b0, 1'b0, 4'h0, 6'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
